// File: rtl/regfile_pkg.sv
// Shared constants and the load-result entry type for the register file writeback path.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with modulo-DEPTH pointers; push when full and pop when empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: ALU results win over buffered load results,
// with a pending-load scoreboard for decode operand stalls.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      q_r1,
  input  logic [4:0]      q_r2,
  output logic            busy_r1,
  output logic            busy_r2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic            w_en,
  output logic [1:0]      fifo_count
);
  import regfile_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  wb_entry_t       fifo_din, fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic            push, pop;
  logic [NREG-1:0] pending, pending_nxt;

  assign fifo_din   = '{rd: ld_rd, data: ld_data};
  assign ld_ready   = !fifo_full && !rst;
  assign push       = ld_valid && ld_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign fifo_count = 2'(fifo_cnt);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd         <= '0;
      write_data <= '0;
      w_en       <= 1'b0;
    end else if (alu_valid) begin
      rd         <= alu_rd;
      write_data <= alu_data;
      w_en       <= (alu_rd != '0);
    end else if (pop) begin
      rd         <= fifo_head.rd;
      write_data <= fifo_head.data;
      w_en       <= (fifo_head.rd != '0);
    end else begin
      w_en       <= 1'b0;
    end
  end

  // Clear before set so a same-edge reissue of the popped register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[fifo_head.rd] = 1'b0;
    if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign busy_r1 = pending[q_r1] && (q_r1 != '0);
  assign busy_r2 = pending[q_r2] && (q_r2 != '0);
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, q_r1, q_r2, rd;
  logic [31:0] alu_data, ld_data, write_data;
  logic        ld_ready, busy_r1, busy_r2, w_en;
  logic [1:0]  fifo_count;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_r1(q_r1), .q_r2(q_r2), .busy_r1(busy_r1), .busy_r2(busy_r2),
    .rd(rd), .write_data(write_data), .w_en(w_en), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  localparam int DEPTH = 2;

  int          vectors = 0;
  int          miscompares = 0;
  ent_t        mq[$];
  bit          pend[32];
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  logic        e_wen;
  bit          accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                        input bit iv, input logic [4:0] ir);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
    issue_valid = iv; issue_rd = ir;
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    e_rd = '0; e_wd = '0; e_wen = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
  task automatic cycle();
    ent_t e;
    bit   mpush;
    #1;
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, mq.size() < DEPTH});
    chk("fifo_count", {30'b0, fifo_count}, 32'(mq.size()));
    chk("busy_r1", {31'b0, busy_r1}, {31'b0, (q_r1 != 0) && pend[q_r1]});
    chk("busy_r2", {31'b0, busy_r2}, {31'b0, (q_r2 != 0) && pend[q_r2]});
    mpush = ld_valid && (mq.size() < DEPTH);
    accepted = mpush;
    @(posedge clk);
    if (alu_valid) begin
      e_rd = alu_rd; e_wd = alu_data; e_wen = (alu_rd != 0);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      e_rd = e.rd; e_wd = e.data; e_wen = (e.rd != 0);
      pend[e.rd] = 1'b0;
    end else begin
      e_wen = 1'b0;
    end
    if (mpush) begin
      e.rd = ld_rd; e.data = ld_data;
      mq.push_back(e);
    end
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
    #1;
    chk("w_en", {31'b0, w_en}, {31'b0, e_wen});
    chk("rd", {27'b0, rd}, {27'b0, e_rd});
    chk("write_data", write_data, e_wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    bit          lv_hold;
    bit          lv, iv;
    logic [4:0]  lr, ir;
    logic [31:0] ldd;
    int          li;

    rst = 1'b1; q_r1 = 0; q_r2 = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_w_en", {31'b0, w_en}, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_fifo_count", {30'b0, fifo_count}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU path, including a write to r0
    set_in(1, 7, 32'h7fff_ffff, 0, 0, 0, 0, 0); cycle();
    idle(1);
    set_in(1, 0, 32'h1234, 0, 0, 0, 0, 0); cycle();
    idle(1);

    // Issue, load and scoreboard clear
    q_r1 = 5;
    set_in(0, 0, 0, 0, 0, 0, 1, 5); cycle();
    idle(1);
    set_in(0, 0, 0, 1, 5, 32'hA, 0, 0); cycle();
    idle(3);

    // ALU burst with back-pressured loads to r1..r3
    for (int r = 1; r <= 3; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 5'(r)); cycle();
    end
    q_r1 = 2; q_r2 = 3;
    li = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(k < 4, 5'(10 + k), 32'(32'h100 + k),
             li < 3, 5'(li + 1), 32'(32'h200 + li), 0, 0);
      cycle();
      if (accepted) li++;
    end

    // Pop of r9 on the same edge as a reissue of r9
    q_r1 = 9; q_r2 = 0;
    set_in(0, 0, 0, 0, 0, 0, 1, 9); cycle();
    set_in(0, 0, 0, 1, 9, 32'h99, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1, 9); cycle();
    idle(2);
    set_in(0, 0, 0, 0, 0, 0, 1, 0); cycle();
    idle(1);

    // Full FIFO with ALU write and a refused offer
    set_in(1, 20, 32'hA20, 1, 21, 32'hD21, 0, 0); cycle();
    set_in(1, 22, 32'hA22, 1, 23, 32'hD23, 0, 0); cycle();
    set_in(1, 24, 32'hA24, 1, 25, 32'hD25, 0, 0); cycle();
    for (int k = 0; k < 4 && !accepted; k++) begin
      set_in(0, 0, 0, 1, 25, 32'hD25, 0, 0); cycle();
    end
    idle(3);

    // Reset with two loads buffered and r5 pending
    q_r1 = 5;
    set_in(1, 3, 32'h33, 1, 5, 32'h55, 1, 5); cycle();
    set_in(1, 4, 32'h44, 1, 6, 32'h66, 1, 6); cycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_w_en", {31'b0, w_en}, 32'd0);
    chk("midrst_fifo_count", {30'b0, fifo_count}, 32'd0);
    chk("midrst_busy_r5", {31'b0, busy_r1}, 32'd0);
    chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("post_rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    idle(2);

    // Random traffic; a refused load offer is held stable
    lv_hold = 0; lv = 0; lr = 0; ldd = 0;
    for (int k = 0; k < 600; k++) begin
      if (!lv_hold) begin
        lv = ($urandom_range(0, 1) == 1);
        lr = 5'($urandom_range(0, 31));
        ldd = $urandom;
      end
      ir = 5'($urandom_range(0, 31));
      iv = ($urandom_range(0, 3) == 0) && !pend[ir];
      q_r1 = 5'($urandom_range(0, 31));
      q_r2 = 5'($urandom_range(0, 31));
      set_in($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
             lv, lr, ldd, iv, ir);
      cycle();
      lv_hold = lv && !accepted;
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
